// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer: channel count,
// channel index type, select encodings and the round-robin step helper.
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH0 = 2'd0;
    localparam ch_idx_t CH1 = 2'd1;
    localparam ch_idx_t CH2 = 2'd2;
    localparam ch_idx_t CH3 = 2'd3;

    // Next channel in round-robin order; 2-bit arithmetic wraps CH3 -> CH0.
    function automatic ch_idx_t ch_next(input ch_idx_t ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/demultiplexer_if.sv
// Producer/consumer handshake bundle of the demultiplexer.
// The slave modport is the demultiplexer's view, the master modport is the
// surrounding producer/consumers (or a testbench).
interface demultiplexer_if #(
    parameter int WIDTH = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data0,
        output out_data1,
        output out_data2,
        output out_data3
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data0,
        input  out_data1,
        input  out_data2,
        input  out_data3
    );

endinterface

// File: rtl/demux_slot.sv
// One output channel: a single-entry valid/ready holding register plus a
// saturating count of completed deliveries.
module demux_slot #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_ready,
    input  logic                 i_cnt_clr,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_data,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_deliver;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        if (val == CNT_MAX) begin
            return val;
        end else begin
            return val + CNT_ONE;
        end
    endfunction

    // A delivery is a cycle where the slot is full and the consumer accepts.
    always_comb begin
        w_deliver = r_valid && i_ready;
    end

    // Slot register: load wins over drain so a drain+load keeps valid high
    // with the new data; a drain alone keeps the last data on the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_deliver) begin
            r_valid <= 1'b0;
            r_data  <= r_data;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    // Delivery counter: clear beats increment, so a delivery in the clear
    // cycle is dropped from the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= {CNT_WIDTH{1'b0}};
        end else if (i_cnt_clr) begin
            r_cnt <= {CNT_WIDTH{1'b0}};
        end else if (w_deliver) begin
            r_cnt <= sat_inc(r_cnt);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/demultiplexer.sv
// 1-to-4 demultiplexer: routes the producer stream to one of four
// independently handshaked output slots, chosen by sel or a round-robin
// pointer, with per-channel delivery counters readable via cnt_sel.
module demultiplexer
    import demux_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demultiplexer_if.slave       bus,
    input  logic [1:0]           sel,
    input  logic                 rr_mode,
    input  logic                 cnt_clr,
    input  logic [1:0]           cnt_sel,
    output logic [CNT_WIDTH-1:0] cnt_value
);

    ch_idx_t              r_rr_ptr;
    ch_idx_t              w_target;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [NUM_CH-1:0]    w_load;
    logic [NUM_CH-1:0]    w_out_valid;
    logic [WIDTH-1:0]     w_out_data [NUM_CH];
    logic [CNT_WIDTH-1:0] w_cnt      [NUM_CH];

    // Target channel follows the mode input in the same cycle.
    always_comb begin
        if (rr_mode) begin
            w_target = r_rr_ptr;
        end else begin
            w_target = ch_idx_t'(sel);
        end
    end

    // Ready when the target slot is empty or is being drained this cycle;
    // other channels' state never affects the producer.
    always_comb begin
        w_in_ready = !w_out_valid[w_target] || bus.out_ready[w_target];
        w_accept   = bus.in_valid && w_in_ready;
    end

    // Decode the accepted transfer into a one-hot load strobe.
    always_comb begin
        w_load = 4'b0000;
        case (w_target)
            CH0:     w_load = {3'b000, w_accept};
            CH1:     w_load = {2'b00, w_accept, 1'b0};
            CH2:     w_load = {1'b0, w_accept, 2'b00};
            CH3:     w_load = {w_accept, 3'b000};
            default: w_load = 4'b0000;
        endcase
    end

    // Round-robin pointer advances only on accepted transfers in rr mode;
    // it does not skip a stalled channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= CH0;
        end else if (w_accept && rr_mode) begin
            r_rr_ptr <= ch_next(r_rr_ptr);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_slot #(
            .WIDTH     (WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_load    (w_load[g]),
            .i_data    (bus.in_data),
            .i_ready   (bus.out_ready[g]),
            .i_cnt_clr (cnt_clr),
            .o_valid   (w_out_valid[g]),
            .o_data    (w_out_data[g]),
            .o_cnt     (w_cnt[g])
        );
    end

    // Counter readback mux.
    always_comb begin
        cnt_value = {CNT_WIDTH{1'b0}};
        case (ch_idx_t'(cnt_sel))
            CH0:     cnt_value = w_cnt[0];
            CH1:     cnt_value = w_cnt[1];
            CH2:     cnt_value = w_cnt[2];
            CH3:     cnt_value = w_cnt[3];
            default: cnt_value = {CNT_WIDTH{1'b0}};
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data0 = w_out_data[0];
    assign bus.out_data1 = w_out_data[1];
    assign bus.out_data2 = w_out_data[2];
    assign bus.out_data3 = w_out_data[3];

endmodule

// File: doc/demultiplexer.md
Name: demultiplexer

Overview:
- 1-to-4 demultiplexer; the inverse of the team's 4:1 selector.
- Routes a WIDTH-bit data stream to one of four registered output channels, chosen either by an explicit `sel` or by an internal round-robin pointer.
- Each channel has a one-entry valid/ready holding slot, so a stalled consumer blocks only its own channel.
- Per-channel delivery counters can be read back through a counter-select port. Sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 4, data width of input and each output channel
- CNT_WIDTH, 8, width of each per-channel delivery counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  producer has data
- in_ready  output  1  block can accept data this cycle
- in_data  input  WIDTH  producer data
- sel  input  2  target channel in select mode (00→ch0, 01→ch1, 10→ch2, 11→ch3)
- rr_mode  input  1  1 = round-robin distribution, 0 = sel-directed
- out_valid  output  4  bit i: channel i slot holds data
- out_ready  input  4  bit i: consumer i accepts
- out_data0..out_data3  output  WIDTH each  channel slot data
- cnt_clr  input  1  synchronous clear of all delivery counters
- cnt_sel  input  2  counter readback select
- cnt_value  output  CNT_WIDTH  delivery count of channel cnt_sel (combinational)

Behaviour:
- Reset: when rst_n is low at a clk edge, all of the following clear to 0; slot contents are discarded, including mid-transfer:
  - out_valid = 0000 and out_data0..3 = 0
  - rr_ptr = 0
  - all counters = 0
- Target selection: target = rr_mode ? rr_ptr : sel. A mode change takes effect in the same cycle.
- Input handshake:
  - in_ready = !out_valid[target] || out_ready[target]; combinational, no registered bubble.
  - accept = in_valid && in_ready.
  - If in_valid is high and in_ready is low, no state changes; the producer holds in_data.
- Slot update per channel i, each edge, in priority order:
  1. accept with target == i: load in_data and set out_valid[i] = 1. This covers simultaneous drain and load; valid stays 1 and the new data appears.
  2. out_valid[i] && out_ready[i]: clear out_valid[i]; out_data[i] keeps its last value.
  3. Otherwise hold. out_data[i] is stable while out_valid[i] is high and out_ready[i] is low.
- Latency: data accepted at edge N is visible on out_dataX with out_validX high after edge N. Full throughput is one transfer per cycle when the consumer is ready.
- Round-robin:
  - rr_ptr (2 bits) increments by 1 on each accept while rr_mode = 1 and wraps 3→0.
  - It holds while rr_mode = 0 and does not skip stalled channels; the producer stalls until the target frees.
- Delivery counters:
  - cnt[i] increments on each out_valid[i] && out_ready[i] and saturates at 2^CNT_WIDTH−1.
  - cnt_clr has priority over increment; a delivery in the clear cycle is not counted.
- cnt_value = cnt[cnt_sel], combinational.
- Channels are independent: deliveries on other channels proceed regardless of stalls on the target.

Decomposition:
- Package demux_pkg:
  - constant NUM_CH = 4
  - channel index typedef (2-bit)
  - select encodings CH0..CH3
- Sub-module demux_slot: one-entry holding register with load/valid/ready/data and a saturating delivery counter. Instantiated 4×.
- Top level holds target mux, rr_ptr, in_ready logic and counter readback mux.

Test Plan:
- Reset: assert rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0000, out_data0..3 = 0, cnt_value = 0 for all cnt_sel; afterwards the first rr accept goes to ch0.
- Select mode: out_ready = 1111, sel = 10, in_data = A for 1 cycle → next cycle out_valid = 0100, out_data2 = A; cnt[2] = 1; other channels unchanged.
- Stall isolation: out_ready[1] = 0, send B to ch1, then C to ch1 → in_ready = 0 on the second transfer; out_data1 stays B. Send D to ch3 in the same window → D is delivered. Raising out_ready[1] → C loads in the same cycle B drains.
- Round-robin wrap: rr_mode = 1, all ready, stream 1,2,3,4,5 → ch0..ch3 receive 1,2,3,4 and ch0 receives 5; rr_ptr = 1 at the end.
- Counter saturation/clear: CNT_WIDTH = 2, deliver 5 items to ch0 → cnt_value = 3. Assert cnt_clr with a simultaneous delivery → cnt_value = 0.
- Mid-operation reset: ch2 is full and stalled; pulse rst_n low for 1 cycle → out_valid[2] = 0, data lost, rr_ptr = 0.
